// File: rtl/matrices_pkg.sv
// Shared types and constants for the Matrices ROM read-side sequencer.
package matrices_pkg;

    localparam int LATENCY        = 2;
    localparam int DEF_ADDR_WIDTH = 7;
    // Row field is sized generously so the tag type does not depend on ADDR_WIDTH.
    localparam int TAG_ROW_W      = 16;

    function automatic int beats_per_row(input int addr_width);
        return (2 ** addr_width) / 8;
    endfunction

    localparam int BEATS_PER_ROW = beats_per_row(DEF_ADDR_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic                 last;
        logic [TAG_ROW_W-1:0] row;
    } tag_t;

endpackage

// File: rtl/dot8_sum.sv
// Eight-lane unsigned multiply with a balanced adder tree; result wraps at 2*DATA_WIDTH bits.
module dot8_sum #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [8*DATA_WIDTH-1:0] a_i,
    input  logic [8*DATA_WIDTH-1:0] b_i,
    output logic [2*DATA_WIDTH-1:0] sum_o
);

    localparam int RW = 2 * DATA_WIDTH;

    logic [RW-1:0] prod [8];
    logic [RW-1:0] s1   [4];
    logic [RW-1:0] s2   [2];

    always_comb begin
        for (int j = 0; j < 8; j++) begin
            prod[j] = RW'(a_i[j*DATA_WIDTH +: DATA_WIDTH]) * RW'(b_i[j*DATA_WIDTH +: DATA_WIDTH]);
        end
        for (int j = 0; j < 4; j++) begin
            s1[j] = prod[2*j] + prod[2*j+1];
        end
        for (int j = 0; j < 2; j++) begin
            s2[j] = s1[2*j] + s1[2*j+1];
        end
        sum_o = s2[0] + s2[1];
    end

endmodule

// File: rtl/matvec_checker.sv
// Walks matrix A and vector B eight elements per cycle, accumulates one dot product
// per row and compares it with the expected value read from ROM C.
module matvec_checker
    import matrices_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7,
    parameter int LATENCY    = matrices_pkg::LATENCY
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    output logic [2*ADDR_WIDTH-1:0] romA_addrA,
    output logic [2*ADDR_WIDTH-1:0] romA_addrB,
    output logic [ADDR_WIDTH-1:0]   romB_addrA,
    output logic [ADDR_WIDTH-1:0]   romB_addrB,
    output logic [ADDR_WIDTH-1:0]   romC_addrA,
    output logic [ADDR_WIDTH-1:0]   romC_addrB,
    input  logic [4*DATA_WIDTH-1:0] romA_busA,
    input  logic [4*DATA_WIDTH-1:0] romA_busB,
    input  logic [4*DATA_WIDTH-1:0] romB_busA,
    input  logic [4*DATA_WIDTH-1:0] romB_busB,
    input  logic [2*DATA_WIDTH-1:0] romC_dataA,
    input  logic [2*DATA_WIDTH-1:0] romC_dataB,
    output logic                    busy,
    output logic                    done,
    output logic                    res_valid,
    output logic [ADDR_WIDTH-1:0]   res_row,
    output logic [2*DATA_WIDTH-1:0] res_value,
    output logic [2*DATA_WIDTH-1:0] res_expected,
    output logic                    res_match,
    output logic [ADDR_WIDTH:0]     mismatch_count
);

    localparam int AW2    = 2 * ADDR_WIDTH;
    localparam int RW     = 2 * DATA_WIDTH;
    localparam int N      = 2 ** ADDR_WIDTH;
    localparam int BEATS  = beats_per_row(ADDR_WIDTH);
    localparam int BEAT_W = ADDR_WIDTH - 3;
    localparam int DRW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [AW2-1:0] STEP    = AW2'(8);
    localparam logic [AW2-1:0] LANE_HI = AW2'(4);

    // Handshake: start is a one-cycle request honoured only in IDLE outside the done
    // cycle; res_valid is a single-cycle strobe with no backpressure.
    state_t         state_q, state_d;
    logic [AW2-1:0] pos_q, pos_d;
    logic [AW2-1:0] addr_b_q, addr_b_d;
    logic [DRW-1:0] drain_q, drain_d;
    logic           start_ok, issue_last, run_last;
    tag_t           issue_tag, ret_tag;
    tag_t           pipe_q [LATENCY];

    logic [RW-1:0]         beat_sum, acc_sum;
    logic [RW-1:0]         acc_q, acc_d;
    logic                  res_valid_q, res_valid_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] res_row_q, res_row_d;
    logic [RW-1:0]         res_value_q, res_value_d;
    logic [RW-1:0]         res_expected_q, res_expected_d;
    logic                  res_match_q, res_match_d;
    logic [ADDR_WIDTH:0]   mismatch_q, mismatch_d;

    // pos_q is the romA port-A address; row and beat are its upper and middle fields.
    always_comb begin
        start_ok        = start && (state_q == ST_IDLE) && !done_q;
        issue_last      = (pos_q[ADDR_WIDTH-1:3] == BEAT_W'(BEATS - 1));
        run_last        = issue_last && (pos_q[AW2-1:ADDR_WIDTH] == ADDR_WIDTH'(N - 1));
        issue_tag.valid = (state_q == ST_ISSUE);
        issue_tag.last  = issue_last;
        issue_tag.row   = TAG_ROW_W'(pos_q[AW2-1:ADDR_WIDTH]);
    end

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        addr_b_d = addr_b_q;
        drain_d  = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d  = ST_ISSUE;
                    pos_d    = '0;
                    addr_b_d = LANE_HI;
                end
            end
            ST_ISSUE: begin
                pos_d    = pos_q + STEP;
                addr_b_d = pos_q + STEP + LANE_HI;
                if (run_last) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRW'(LATENCY - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    drain_d = drain_q + DRW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pos_q    <= '0;
            addr_b_q <= '0;
            drain_q  <= '0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            addr_b_q <= addr_b_d;
            drain_q  <= drain_d;
        end
    end

    // Tag travels alongside the ROM read so its last stage lines up with returning data.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= issue_tag;
            for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign ret_tag = pipe_q[LATENCY-1];

    dot8_sum #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_dot8_sum (
        .a_i  ({romA_busB, romA_busA}),
        .b_i  ({romB_busB, romB_busA}),
        .sum_o(beat_sum)
    );

    always_comb begin
        acc_sum        = acc_q + beat_sum;
        acc_d          = acc_q;
        res_valid_d    = 1'b0;
        done_d         = 1'b0;
        res_row_d      = res_row_q;
        res_value_d    = res_value_q;
        res_expected_d = res_expected_q;
        res_match_d    = res_match_q;
        mismatch_d     = mismatch_q;
        if (start_ok) begin
            acc_d      = '0;
            mismatch_d = '0;
        end else if (ret_tag.valid) begin
            acc_d = ret_tag.last ? '0 : acc_sum;
            if (ret_tag.last) begin
                res_valid_d    = 1'b1;
                res_row_d      = ret_tag.row[ADDR_WIDTH-1:0];
                res_value_d    = acc_sum;
                res_expected_d = romC_dataA;
                res_match_d    = (acc_sum == romC_dataA);
                done_d         = (ret_tag.row == TAG_ROW_W'(N - 1));
                if (acc_sum != romC_dataA) mismatch_d = mismatch_q + (ADDR_WIDTH+1)'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q          <= '0;
            res_valid_q    <= 1'b0;
            done_q         <= 1'b0;
            res_row_q      <= '0;
            res_value_q    <= '0;
            res_expected_q <= '0;
            res_match_q    <= 1'b0;
            mismatch_q     <= '0;
        end else begin
            acc_q          <= acc_d;
            res_valid_q    <= res_valid_d;
            done_q         <= done_d;
            res_row_q      <= res_row_d;
            res_value_q    <= res_value_d;
            res_expected_q <= res_expected_d;
            res_match_q    <= res_match_d;
            mismatch_q     <= mismatch_d;
        end
    end

    assign romA_addrA     = pos_q;
    assign romA_addrB     = addr_b_q;
    assign romB_addrA     = pos_q[ADDR_WIDTH-1:0];
    assign romB_addrB     = addr_b_q[ADDR_WIDTH-1:0];
    assign romC_addrA     = pos_q[AW2-1:ADDR_WIDTH];
    assign romC_addrB     = pos_q[AW2-1:ADDR_WIDTH];
    // done_q keeps busy high through the final result cycle after the FSM is back in IDLE.
    assign busy           = (state_q != ST_IDLE) || done_q;
    assign done           = done_q;
    assign res_valid      = res_valid_q;
    assign res_row        = res_row_q;
    assign res_value      = res_value_q;
    assign res_expected   = res_expected_q;
    assign res_match      = res_match_q;
    assign mismatch_count = mismatch_q;

endmodule

// File: tb/tb_matvec_checker.sv
// Directed bench for matvec_checker: a latency-2 ROM model plus per-row expected results.
module tb_matvec_checker;

    localparam int N = 128;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [13:0] romA_addrA, romA_addrB;
    logic [6:0]  romB_addrA, romB_addrB, romC_addrA, romC_addrB;
    logic [31:0] romA_busA, romA_busB, romB_busA, romB_busB;
    logic [15:0] romC_dataA, romC_dataB;
    logic        busy, done, res_valid, res_match;
    logic [6:0]  res_row;
    logic [15:0] res_value, res_expected;
    logic [7:0]  mismatch_count;

    logic [7:0]  mem_a [0:N*N-1];
    logic [7:0]  mem_b [0:N-1];
    logic [15:0] mem_c [0:N-1];

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q [$];
    logic [15:0] expc_q [$];

    always #5 clock = ~clock;

    matvec_checker dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .romA_addrA    (romA_addrA),
        .romA_addrB    (romA_addrB),
        .romB_addrA    (romB_addrA),
        .romB_addrB    (romB_addrB),
        .romC_addrA    (romC_addrA),
        .romC_addrB    (romC_addrB),
        .romA_busA     (romA_busA),
        .romA_busB     (romA_busB),
        .romB_busA     (romB_busA),
        .romB_busB     (romB_busB),
        .romC_dataA    (romC_dataA),
        .romC_dataB    (romC_dataB),
        .busy          (busy),
        .done          (done),
        .res_valid     (res_valid),
        .res_row       (res_row),
        .res_value     (res_value),
        .res_expected  (res_expected),
        .res_match     (res_match),
        .mismatch_count(mismatch_count)
    );

    // ROM model: address sampled at one edge, data driven at the next (two-cycle latency).
    function automatic logic [31:0] rd_a(input logic [13:0] ad);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[j*8 +: 8] = mem_a[ad + 14'(j)];
        return r;
    endfunction

    function automatic logic [31:0] rd_b(input logic [6:0] ad);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[j*8 +: 8] = mem_b[ad + 7'(j)];
        return r;
    endfunction

    logic [13:0] ra_a = '0, ra_b = '0;
    logic [6:0]  rb_a = '0, rb_b = '0, rc = '0;

    always @(posedge clock) begin
        ra_a       <= romA_addrA;
        ra_b       <= romA_addrB;
        rb_a       <= romB_addrA;
        rb_b       <= romB_addrB;
        rc         <= romC_addrA;
        romA_busA  <= rd_a(ra_a);
        romA_busB  <= rd_a(ra_b);
        romB_busA  <= rd_b(rb_a);
        romB_busB  <= rd_b(rb_b);
        romC_dataA <= mem_c[rc];
        romC_dataB <= ~mem_c[rc];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic any_out();
        return |{romA_addrA, romA_addrB, romB_addrA, romB_addrB, romC_addrA, romC_addrB,
                 busy, done, res_valid, res_row, res_value, res_expected, res_match,
                 mismatch_count};
    endfunction

    // pat 0: all ones, 1: all 0xFF, 2: A diagonal of 3 with B[c] = c (row r sums to 3r).
    task automatic fill(input int pat, input int bad_row);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                mem_a[14'(r*N + c)] = (pat == 1) ? 8'hFF : (pat == 2) ? ((r == c) ? 8'd3 : 8'd0) : 8'd1;
            end
            mem_b[7'(r)] = (pat == 1) ? 8'hFF : (pat == 2) ? 8'(r) : 8'd1;
            mem_c[7'(r)] = (pat == 2) ? 16'(3*r) : 16'h0080;
            if (r == bad_row) mem_c[7'(r)] = 16'h0081;
            exp_q.push_back((pat == 2) ? 16'(3*r) : 16'h0080);
            expc_q.push_back(mem_c[7'(r)]);
        end
    endtask

    // Starts a run at the current negedge (cycle 0) and observes it for last_rel cycles.
    task automatic run_check(input int last_rel, input bit stray, input int reset_at,
                             input int exp_rows, input int exp_mm);
        int rel = 0;
        int rows = 0;
        int dones = 0;
        int busy_bad = 0;
        bit exp_busy;
        logic [15:0] ev, ec;
        start = 1'b1;
        while (rel < last_rel) begin
            @(negedge clock);
            rel++;
            if (rel == 1) begin
                start = 1'b0;
                check("mm_cleared", 32'(mismatch_count), 0);
                check("addr_c1_a", {4'd0, romA_addrA, romA_addrB}, {4'd0, 14'd0, 14'd4});
                check("addr_c1_bc", {11'd0, romB_addrA, romB_addrB, romC_addrA}, {11'd0, 7'd0, 7'd4, 7'd0});
            end
            if (rel == 16) begin
                check("addr_c16_a", {4'd0, romA_addrA, romA_addrB}, {4'd0, 14'd120, 14'd124});
                check("addr_c16_bc", {11'd0, romB_addrA, romB_addrB, romC_addrA}, {11'd0, 7'd120, 7'd124, 7'd0});
            end
            if (rel == 17) begin
                check("addr_c17_a", {4'd0, romA_addrA, romA_addrB}, {4'd0, 14'd128, 14'd132});
                check("addr_c17_bc", {11'd0, romB_addrA, romB_addrB, romC_addrB}, {11'd0, 7'd0, 7'd4, 7'd1});
            end
            if (stray && (rel == 500 || rel == 2051)) start = 1'b1;
            if (stray && (rel == 501 || rel == 2052)) start = 1'b0;
            exp_busy = (rel <= ((reset_at > 0) ? reset_at : 2051));
            if (busy !== exp_busy) busy_bad++;
            if (res_valid) begin
                rows++;
                if (exp_q.size() > 0) begin
                    ev = exp_q.pop_front();
                    ec = expc_q.pop_front();
                    check("res_value", 32'(res_value), 32'(ev));
                    check("res_expected", 32'(res_expected), 32'(ec));
                    check("res_match", 32'(res_match), 32'(ev == ec));
                end
                check("res_row", 32'(res_row), rows - 1);
                check("res_cycle", rel, 16*(rows - 1) + 19);
            end
            if (done) begin
                dones++;
                check("done_cycle", rel, 2051);
                check("mm_final", 32'(mismatch_count), exp_mm);
            end
            if (reset_at > 0 && rel == reset_at) begin
                check("mm_before_rst", 32'(mismatch_count), exp_mm);
                reset = 1'b1;
            end
            if (reset_at > 0 && rel == reset_at + 1) begin
                check("rst_midrun_outs", 32'(any_out()), 0);
                reset = 1'b0;
            end
        end
        check("row_count", rows, exp_rows);
        check("busy_window", busy_bad, 0);
        check("done_count", dones, (reset_at > 0) ? 0 : 1);
        exp_q.delete();
        expc_q.delete();
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("rst_init_outs", 32'(any_out()), 0);
        reset = 1'b0;
        @(negedge clock);

        fill(0, -1);
        run_check(2060, 1'b0, 0, 128, 0);
        // Corrupted C[5], with start pulses at 500 and 2051 that must be ignored.
        fill(0, 5);
        run_check(2052, 1'b1, 0, 128, 1);
        // Started at cycle 2052 of the previous run: mismatch_count must clear.
        fill(1, -1);
        run_check(2060, 1'b0, 0, 128, 0);
        fill(2, -1);
        run_check(2060, 1'b0, 0, 128, 0);
        fill(0, 5);
        run_check(1100, 1'b0, 1000, 62, 1);
        fill(0, -1);
        run_check(2060, 1'b0, 0, 128, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matvec_checker.md
# matvec_checker

Read-side sequencer for the `Matrices` ROM block. It walks matrix A (128×128, row-major, 8-bit) and vector B (128×8-bit), and fetches eight elements per cycle over the two 4-wide ports. For each row it accumulates the dot product and compares it against the 16-bit expected value from ROM C. It reports one result per row, plus a mismatch count and a completion pulse.

## Interface
- `DATA_WIDTH`, default 8: element width; products and results are 2*DATA_WIDTH.
- `ADDR_WIDTH`, default 7: N = 2**ADDR_WIDTH rows/columns; ROM A address is 2*ADDR_WIDTH.
- `LATENCY`, default 2: cycles from address driven to data on the `Matrices` output buses.

- `clock` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `romA_addrA`, `romA_addrB` out 2*ADDR_WIDTH: A word addresses; bus lane j returns A[addr+j].
- `romB_addrA`, `romB_addrB` out ADDR_WIDTH: B addresses; lane j returns B[addr+j].
- `romC_addrA`, `romC_addrB` out ADDR_WIDTH: expected-result address (both ports driven identically).
- `romA_busA`, `romA_busB`, `romB_busA`, `romB_busB` in 4×DATA_WIDTH: ROM data buses.
- `romC_dataA` in 2*DATA_WIDTH: expected value; `romC_dataB` ignored.
- `busy` out 1: high from the cycle after start acceptance through the done cycle.
- `done` out 1: one-cycle pulse, coincident with the last `res_valid`.
- `res_valid` out 1: one row result this cycle; there is no backpressure.
- `res_row` out ADDR_WIDTH: row index.
- `res_value` out 2*DATA_WIDTH: computed dot product mod 2^(2*DATA_WIDTH).
- `res_expected` out 2*DATA_WIDTH: ROM C value for the row.
- `res_match` out 1: `res_value == res_expected`.
- `mismatch_count` out ADDR_WIDTH+1: count of mismatching rows in the current run.

## Operation
- **FSM states:** IDLE, ISSUE, DRAIN.
- **IDLE → ISSUE:** on `start`. `mismatch_count` and the accumulator are cleared at the same time.
- **ISSUE:** registered address outputs advance one beat per cycle. Beat k (0..15) of row r drives:
  - `romA_addrA` = r*N + 8k, `romA_addrB` = r*N + 8k + 4
  - `romB_addrA` = 8k, `romB_addrB` = 8k + 4
  - `romC_addr*` = r
  - Rows are issued back-to-back with no bubble. After beat 15 of row N−1, go to DRAIN.
- **DRAIN:** lasts LATENCY cycles. Then return to IDLE.
- **Valid pipeline:** a LATENCY-deep shift register carries valid, a last-beat flag and the row index, aligned with returning data.
- **Per returning beat:** compute the sum of 8 lane products (unsigned, 8×8→16) and add it to the accumulator modulo 2^(2*DATA_WIDTH).
- **On the last beat of a row:** register the final sum, `romC_dataA`, the row index and the match flag. `res_valid` rises the next cycle, and the accumulator restarts from 0 in the same cycle with no lost beat.
- **Mismatch counting:** `mismatch_count` increments with each `res_valid` where `res_match` = 0. At most N, so it never wraps.
- **`start` while busy:** ignored, with no effect.
- **`start` in the done cycle:** ignored; `start` is accepted only in IDLE, i.e. from the cycle after `done`.
- **Address range:** addresses never exceed N*N−1; no wrap handling is needed.

## Timing
- **Start:** accepted at edge E0, i.e. `start` high in cycle 0. The first beat's addresses are on the outputs in cycle 1, and its data is on the buses in cycle 1+LATENCY.
- **Per row:** 16 cycles. Row r's `res_valid` is in cycle 16r + 16 + LATENCY + 1.
- **Full run:** last address cycle 2048, last data cycle 2050, final `res_valid` and `done` in cycle 2051. `busy` is high in cycles 1–2051.
- **Reset values:** all outputs 0, FSM in IDLE, valid pipeline cleared.
- **Reset mid-run:** in-flight beats are discarded, no `res_valid` appears after reset, and `mismatch_count` returns to 0.

## Structure
- **Package `matrices_pkg`:**
  - state enum
  - `LATENCY`
  - `BEATS_PER_ROW = N/8`
  - a pipeline-tag struct {valid, last, row}
- **Sub-module `dot8_sum`:** 8-lane unsigned multiply plus adder tree, combinational, 2*DATA_WIDTH output modulo.
- **Top level:** FSM, address counters, tag pipeline, accumulator, result register and counter.

## Test plan
- **All ones:** A = B = 1 everywhere, C = 0x0080 → 128 `res_valid` pulses, all with `res_match` = 1, `mismatch_count` = 0. `done` in cycle 2051 after start; `busy` drops the next cycle.
- **Corrupted C:** C[5] = 0x0081, otherwise as the all-ones case → row 5 gives `res_value` 0x0080, `res_expected` 0x0081, `res_match` 0. Final `mismatch_count` = 1.
- **Overflow:** A = B = 0xFF, C = 0x0080 → every row gives 128·65025 mod 65536 = 0x0080 and matches.
- **Address trace:**
  - cycle 1: romA 0/4, romB 0/4, romC 0
  - cycle 16: romA 120/124, romB 120/124
  - cycle 17: romA 128/132, romB 0/4, romC 1
- **`start` while busy:** pulse `start` at cycles 500 and 2051 → no restart and no change in results. `start` at 2052 begins a new run, with `mismatch_count` cleared.
- **Reset mid-run:** assert `reset` at cycle 1000 → all outputs 0 the next cycle and no further `res_valid`. A subsequent `start` produces a complete, correct 128-row run.
